// File: rtl/robo_sequenciador.sv
`default_nettype none
// ============================================================================
// Module   : robo_sequenciador
// Brief    : Serialises level commands (avancar/girar/remover) into start/done
//            actuator operations with timeout, stuck detection and step count.
//            Optional ROBO_SEQ_STATS_EN adds giros_total / remocoes_total.
// Revision : 1.0 - initial release
// ============================================================================
module robo_sequenciador #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_GIROS      = 4,
    parameter int PASSOS_W       = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                avancar,
    input  logic                girar,
    input  logic                remover,
    input  logic                clear_fault,
    input  logic                act_done,
    output logic                act_start,
    output logic [1:0]          act_op,
    output logic                busy,
    output logic                cmd_ack,
    output logic                stuck,
    output logic                timeout_err,
    output logic [PASSOS_W-1:0] passos
`ifdef ROBO_SEQ_STATS_EN
    ,
    output logic [PASSOS_W-1:0] giros_total,
    output logic [PASSOS_W-1:0] remocoes_total
`endif
);

    localparam int c_timer_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_giro_w  = $clog2(MAX_GIROS + 1);

    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_giro_w-1:0]  c_giro_last  = c_giro_w'(MAX_GIROS - 1);

    localparam logic [1:0] c_op_none    = 2'b00;
    localparam logic [1:0] c_op_avancar = 2'b01;
    localparam logic [1:0] c_op_girar   = 2'b10;
    localparam logic [1:0] c_op_remover = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_FAULT     = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [c_timer_w-1:0]  timer_q, timer_d;
    logic [c_giro_w-1:0]   giro_q, giro_d;
    logic [PASSOS_W-1:0]   passos_q, passos_d;
    logic                  stuck_q, stuck_d;
    logic                  timeout_q, timeout_d;
    logic                  cmd_ack_q, cmd_ack_d;
`ifdef ROBO_SEQ_STATS_EN
    logic [PASSOS_W-1:0]   giros_total_q, giros_total_d;
    logic [PASSOS_W-1:0]   remocoes_q, remocoes_d;
`endif

    logic w_any_cmd;
    logic w_busy;

    assign w_any_cmd = avancar | girar | remover;
    assign w_busy    = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        timer_d   = timer_q;
        giro_d    = giro_q;
        passos_d  = passos_q;
        stuck_d   = stuck_q;
        timeout_d = timeout_q;
        cmd_ack_d = 1'b0;
`ifdef ROBO_SEQ_STATS_EN
        giros_total_d = giros_total_q;
        remocoes_d    = remocoes_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (enable && w_any_cmd) begin
                    if (remover)      op_d = c_op_remover;
                    else if (girar)   op_d = c_op_girar;
                    else              op_d = c_op_avancar;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                timer_d = timer_q + 1'b1;
                // Completion has priority over a timeout landing in the same cycle.
                if (act_done) begin
                    cmd_ack_d = 1'b1;
                    state_d   = S_IDLE;
                    case (op_q)
                        c_op_avancar: begin
                            if (passos_q != '1) passos_d = passos_q + 1'b1;
                            giro_d = '0;
                        end
                        c_op_girar: begin
                            giro_d = giro_q + 1'b1;
                            if (giro_q == c_giro_last) begin
                                stuck_d = 1'b1;
                                state_d = S_FAULT;
                            end
`ifdef ROBO_SEQ_STATS_EN
                            if (giros_total_q != '1) giros_total_d = giros_total_q + 1'b1;
`endif
                        end
                        c_op_remover: begin
`ifdef ROBO_SEQ_STATS_EN
                            if (remocoes_q != '1) remocoes_d = remocoes_q + 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end else if (timer_q == c_timer_last) begin
                    timeout_d = 1'b1;
                    state_d   = S_FAULT;
                end
            end

            S_FAULT: begin
                if (clear_fault) begin
                    state_d   = S_IDLE;
                    stuck_d   = 1'b0;
                    timeout_d = 1'b0;
                    giro_d    = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= c_op_none;
            timer_q   <= '0;
            giro_q    <= '0;
            passos_q  <= '0;
            stuck_q   <= 1'b0;
            timeout_q <= 1'b0;
            cmd_ack_q <= 1'b0;
`ifdef ROBO_SEQ_STATS_EN
            giros_total_q <= '0;
            remocoes_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            timer_q   <= timer_d;
            giro_q    <= giro_d;
            passos_q  <= passos_d;
            stuck_q   <= stuck_d;
            timeout_q <= timeout_d;
            cmd_ack_q <= cmd_ack_d;
`ifdef ROBO_SEQ_STATS_EN
            giros_total_q <= giros_total_d;
            remocoes_q    <= remocoes_d;
`endif
        end
    end

    // op_q is only meaningful while an operation is in flight.
    assign act_start   = (state_q == S_ISSUE);
    assign busy        = w_busy;
    assign act_op      = w_busy ? op_q : c_op_none;
    assign cmd_ack     = cmd_ack_q;
    assign stuck       = stuck_q;
    assign timeout_err = timeout_q;
    assign passos      = passos_q;
`ifdef ROBO_SEQ_STATS_EN
    assign giros_total    = giros_total_q;
    assign remocoes_total = remocoes_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_robo_sequenciador.sv
`default_nettype none
// ============================================================================
// Module   : tb_robo_sequenciador
// Brief    : Self-checking bench for robo_sequenciador with a reference model
//            and an expected-result queue per completed operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_robo_sequenciador;

    localparam int TO = 8;
    localparam int MG = 4;
    localparam int PW = 4;
    localparam int PMAX = (1 << PW) - 1;

    typedef struct {
        logic [1:0]    op;
        logic [PW-1:0] passos;
        logic          stuck;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          avancar = 1'b0;
    logic          girar = 1'b0;
    logic          remover = 1'b0;
    logic          clear_fault = 1'b0;
    logic          act_done = 1'b0;
    logic          act_start;
    logic [1:0]    act_op;
    logic          busy;
    logic          cmd_ack;
    logic          stuck;
    logic          timeout_err;
    logic [PW-1:0] passos;
`ifdef ROBO_SEQ_STATS_EN
    logic [PW-1:0] giros_total;
    logic [PW-1:0] remocoes_total;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_passos = 0;
    int   m_giros  = 0;
    int   m_gir_total = 0;
    int   m_rem_total = 0;
    exp_t sb_q[$];

    robo_sequenciador #(
        .TIMEOUT_CYCLES(TO),
        .MAX_GIROS     (MG),
        .PASSOS_W      (PW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .avancar    (avancar),
        .girar      (girar),
        .remover    (remover),
        .clear_fault(clear_fault),
        .act_done   (act_done),
        .act_start  (act_start),
        .act_op     (act_op),
        .busy       (busy),
        .cmd_ack    (cmd_ack),
        .stuck      (stuck),
        .timeout_err(timeout_err),
        .passos     (passos)
`ifdef ROBO_SEQ_STATS_EN
        ,
        .giros_total   (giros_total),
        .remocoes_total(remocoes_total)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Reference model: cmd = {remover, girar, avancar}; returns the expected
    // outcome of the operation once it completes.
    function automatic exp_t predict(input logic [2:0] cmd);
        exp_t e;
        e.op = cmd[2] ? 2'b11 : cmd[1] ? 2'b10 : cmd[0] ? 2'b01 : 2'b00;
        if (e.op == 2'b01) begin
            if (m_passos < PMAX) m_passos++;
            m_giros = 0;
        end else if (e.op == 2'b10) begin
            m_giros++;
            if (m_gir_total < PMAX) m_gir_total++;
        end else if (e.op == 2'b11) begin
            if (m_rem_total < PMAX) m_rem_total++;
        end
        e.passos = m_passos[PW-1:0];
        e.stuck  = (m_giros >= MG);
        return e;
    endfunction

    // Drives one operation: waits (bounded) for act_start, returns act_done
    // 'delay' cycles later and reports what was observed.
    task automatic run_op(input logic [2:0] cmd, input logic [2:0] cmd_after,
                          input int delay, output logic [1:0] op_seen,
                          output int n_start, output int n_ack, output bit unstable,
                          output logic [PW-1:0] passos_seen, output logic stuck_seen);
        int w;
        enable = 1'b1;
        {remover, girar, avancar} = cmd;
        op_seen = 2'b00; n_start = 0; n_ack = 0; unstable = 1'b0;
        passos_seen = '0; stuck_seen = 1'b0;
        w = 0;
        while (!act_start && w < 10) begin
            tick;
            w++;
        end
        if (!act_start) begin
            {remover, girar, avancar} = 3'b000;
            return;
        end
        op_seen = act_op;
        n_start = 1;
        {remover, girar, avancar} = cmd_after;
        for (int i = 1; i <= delay; i++) begin
            tick;
            if (act_start) n_start++;
            if (act_op !== op_seen || busy !== 1'b1) unstable = 1'b1;
        end
        act_done = 1'b1;
        tick;
        act_done = 1'b0;
        if (cmd_ack === 1'b1) n_ack++;
        passos_seen = passos;
        stuck_seen  = stuck;
        tick;
        if (cmd_ack === 1'b1) n_ack++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) tick;
        n_checks++;
        if ({act_start, act_op, busy, cmd_ack, stuck, timeout_err, passos} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: outputs=%b expected all zero",
                     {act_start, act_op, busy, cmd_ack, stuck, timeout_err, passos});
        end
        reset = 1'b0;
        tick;
        n_checks++;
        if ({act_start, act_op, busy, cmd_ack, stuck, timeout_err, passos} !== '0) begin
            n_fail++;
            $display("FAIL reset_released: outputs=%b expected all zero",
                     {act_start, act_op, busy, cmd_ack, stuck, timeout_err, passos});
        end
    endtask

    task automatic test_avancar;
        logic [1:0] op; int ns, na; bit un; logic [PW-1:0] ps; logic st; exp_t e;
        sb_q.push_back(predict(3'b001));
        run_op(3'b001, 3'b000, 3, op, ns, na, un, ps, st);
        e = sb_q.pop_front();
        n_checks++;
        if (op !== e.op) begin n_fail++; $display("FAIL avancar_op: got %b expected %b", op, e.op); end
        n_checks++;
        if (ns !== 1) begin n_fail++; $display("FAIL avancar_start_width: got %0d expected 1", ns); end
        n_checks++;
        if (na !== 1) begin n_fail++; $display("FAIL avancar_ack_width: got %0d expected 1", na); end
        n_checks++;
        if (un) begin n_fail++; $display("FAIL avancar_op_stable: act_op/busy changed, expected stable"); end
        n_checks++;
        if (ps !== e.passos) begin n_fail++; $display("FAIL avancar_passos: got %0d expected %0d", ps, e.passos); end
    endtask

    task automatic test_priority;
        logic [1:0] op; int ns, na; bit un; logic [PW-1:0] ps; logic st; exp_t e;
        sb_q.push_back(predict(3'b111));
        run_op(3'b111, 3'b011, 3, op, ns, na, un, ps, st);
        e = sb_q.pop_front();
        n_checks++;
        if (op !== e.op) begin n_fail++; $display("FAIL priority_all: got %b expected %b", op, e.op); end
        sb_q.push_back(predict(3'b011));
        run_op(3'b011, 3'b000, 2, op, ns, na, un, ps, st);
        e = sb_q.pop_front();
        n_checks++;
        if (op !== e.op) begin n_fail++; $display("FAIL priority_held: got %b expected %b", op, e.op); end
        n_checks++;
        if (ps !== e.passos || na !== 1) begin
            n_fail++;
            $display("FAIL priority_done: passos=%0d ack=%0d expected passos=%0d ack=1", ps, na, e.passos);
        end
    endtask

    task automatic test_timeout;
        int w, cnt; bit bad;
        enable = 1'b1;
        avancar = 1'b1;
        w = 0;
        while (!act_start && w < 10) begin tick; w++; end
        avancar = 1'b0;
        cnt = 0;
        tick;
        while (busy && cnt < 20) begin cnt++; tick; end
        n_checks++;
        if (cnt !== TO) begin n_fail++; $display("FAIL timeout_latency: wait cycles=%0d expected %0d", cnt, TO); end
        n_checks++;
        if (timeout_err !== 1'b1 || act_op !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_fault: timeout_err=%b act_op=%b expected 1/00", timeout_err, act_op);
        end
        bad = 1'b0;
        avancar = 1'b1;
        repeat (3) begin
            tick;
            if (act_start || busy || timeout_err !== 1'b1) bad = 1'b1;
        end
        avancar = 1'b0;
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL fault_ignores_cmds: activity in FAULT, expected none"); end
        clear_fault = 1'b1;
        tick;
        clear_fault = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0 || passos !== m_passos[PW-1:0]) begin
            n_fail++;
            $display("FAIL timeout_clear: timeout_err=%b passos=%0d expected 0/%0d", timeout_err, passos, m_passos);
        end
    endtask

    task automatic test_done_at_limit;
        logic [1:0] op; int ns, na; bit un; logic [PW-1:0] ps; logic st; exp_t e;
        sb_q.push_back(predict(3'b001));
        run_op(3'b001, 3'b000, TO, op, ns, na, un, ps, st);
        e = sb_q.pop_front();
        n_checks++;
        if (na !== 1 || timeout_err !== 1'b0 || ps !== e.passos) begin
            n_fail++;
            $display("FAIL done_wins: ack=%0d timeout_err=%b passos=%0d expected 1/0/%0d", na, timeout_err, ps, e.passos);
        end
    endtask

    task automatic test_stuck;
        logic [2:0] seq [0:8];
        logic [1:0] op; int ns, na; bit un; logic [PW-1:0] ps; logic st; exp_t e;
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b010; seq[3] = 3'b010;
        seq[4] = 3'b001; seq[5] = 3'b010; seq[6] = 3'b010; seq[7] = 3'b010;
        seq[8] = 3'b010;
        for (int i = 0; i < 9; i++) begin
            sb_q.push_back(predict(seq[i]));
            run_op(seq[i], 3'b000, 1 + (i % 3), op, ns, na, un, ps, st);
            e = sb_q.pop_front();
            n_checks++;
            if (op !== e.op || st !== e.stuck || ps !== e.passos || na !== 1) begin
                n_fail++;
                $display("FAIL stuck_seq[%0d]: op=%b stuck=%b passos=%0d ack=%0d expected %b/%b/%0d/1",
                         i, op, st, ps, na, e.op, e.stuck, e.passos);
            end
        end
        n_checks++;
        if (stuck !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_fault: stuck=%b busy=%b expected 1/0", stuck, busy);
        end
        clear_fault = 1'b1;
        tick;
        clear_fault = 1'b0;
        m_giros = 0;
        n_checks++;
        if (stuck !== 1'b0 || passos !== m_passos[PW-1:0]) begin
            n_fail++;
            $display("FAIL stuck_clear: stuck=%b passos=%0d expected 0/%0d", stuck, passos, m_passos);
        end
        sb_q.push_back(predict(3'b010));
        run_op(3'b010, 3'b000, 1, op, ns, na, un, ps, st);
        e = sb_q.pop_front();
        n_checks++;
        if (st !== e.stuck || op !== e.op) begin
            n_fail++;
            $display("FAIL giro_after_clear: stuck=%b op=%b expected %b/%b", st, op, e.stuck, e.op);
        end
    endtask

    task automatic test_back_to_back;
        int starts[$]; int bad_gaps;
        enable = 1'b1;
        avancar = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (act_start) starts.push_back(cyc);
            if (cyc >= 15) avancar = 1'b0;
            if (cyc >= 15 && !busy) break;
            act_done = busy && !act_start;
            tick;
        end
        act_done = 1'b0;
        avancar  = 1'b0;
        bad_gaps = 0;
        for (int i = 1; i < starts.size(); i++)
            if (starts[i] - starts[i-1] != 3) bad_gaps++;
        n_checks++;
        if (starts.size() < 4 || bad_gaps != 0) begin
            n_fail++;
            $display("FAIL back_to_back: starts=%0d bad_gaps=%0d expected >=4 starts spaced 3", starts.size(), bad_gaps);
        end
        for (int i = 0; i < starts.size(); i++) void'(predict(3'b001));
        n_checks++;
        if (passos !== m_passos[PW-1:0]) begin
            n_fail++;
            $display("FAIL back_to_back_passos: got %0d expected %0d", passos, m_passos);
        end
    endtask

    task automatic test_enable;
        int w; bit act;
        exp_t e;
        enable = 1'b0;
        avancar = 1'b1;
        act = 1'b0;
        repeat (4) begin tick; if (act_start || busy) act = 1'b1; end
        n_checks++;
        if (act) begin n_fail++; $display("FAIL enable_blocks: operation started, expected none"); end
        enable = 1'b1;
        w = 0;
        while (!act_start && w < 10) begin tick; w++; end
        enable = 1'b0;
        avancar = 1'b0;
        sb_q.push_back(predict(3'b001));
        repeat (2) tick;
        act_done = 1'b1;
        tick;
        act_done = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (cmd_ack !== 1'b1 || passos !== e.passos) begin
            n_fail++;
            $display("FAIL enable_no_abort: cmd_ack=%b passos=%0d expected 1/%0d", cmd_ack, passos, e.passos);
        end
        tick;
        enable = 1'b1;
    endtask

    task automatic test_saturation;
        logic [1:0] op; int ns, na; bit un; logic [PW-1:0] ps; logic st; exp_t e;
        for (int i = 0; i < 17; i++) begin
            sb_q.push_back(predict(3'b001));
            run_op(3'b001, 3'b000, 1, op, ns, na, un, ps, st);
            e = sb_q.pop_front();
            if (ps !== e.passos) begin
                n_checks++;
                n_fail++;
                $display("FAIL saturation_step[%0d]: got %0d expected %0d", i, ps, e.passos);
            end
        end
        n_checks++;
        if (passos !== 4'd15) begin n_fail++; $display("FAIL passos_saturated: got %0d expected 15", passos); end
    endtask

`ifdef ROBO_SEQ_STATS_EN
    task automatic test_stats;
        logic [1:0] op; int ns, na; bit un; logic [PW-1:0] ps; logic st; exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(predict(3'b100));
            run_op(3'b100, 3'b000, 2, op, ns, na, un, ps, st);
            e = sb_q.pop_front();
            n_checks++;
            if (op !== e.op) begin n_fail++; $display("FAIL stats_op[%0d]: got %b expected %b", i, op, e.op); end
        end
        n_checks++;
        if (remocoes_total !== m_rem_total[PW-1:0] || giros_total !== m_gir_total[PW-1:0]) begin
            n_fail++;
            $display("FAIL stats_totals: rem=%0d gir=%0d expected %0d/%0d",
                     remocoes_total, giros_total, m_rem_total, m_gir_total);
        end
    endtask
`endif

    task automatic test_reset_mid;
        int w;
        enable = 1'b1;
        avancar = 1'b1;
        w = 0;
        while (!act_start && w < 10) begin tick; w++; end
        avancar = 1'b0;
        tick;
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({act_start, act_op, busy, cmd_ack, stuck, timeout_err, passos} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: outputs=%b expected all zero",
                     {act_start, act_op, busy, cmd_ack, stuck, timeout_err, passos});
        end
        m_passos = 0; m_giros = 0; m_gir_total = 0; m_rem_total = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        act_done = 1'b1;
        tick;
        act_done = 1'b0;
        n_checks++;
        if (cmd_ack !== 1'b0 || busy !== 1'b0 || passos !== '0) begin
            n_fail++;
            $display("FAIL late_done_ignored: cmd_ack=%b busy=%b passos=%0d expected 0/0/0", cmd_ack, busy, passos);
        end
    endtask

    initial begin
        test_reset;
        test_avancar;
        test_priority;
        test_timeout;
        test_done_at_limit;
        test_stuck;
        test_back_to_back;
        test_enable;
        test_saturation;
`ifdef ROBO_SEQ_STATS_EN
        test_stats;
`endif
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
